// File: rtl/merge_read_scheduler_pkg.sv
// Shared definitions for the merge read scheduler: state encoding and the
// address-info field layout {fdssi, s_addr, e_addr} also used by the frame writer.
package merge_read_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned OUT_FIFO_DEPTH = 4;
  localparam int unsigned EADDR_LSB      = 0;

  function automatic int unsigned saddr_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned fdssi_lsb(input int unsigned aw);
    return 2 * aw;
  endfunction

endpackage

// File: rtl/merge_read_scheduler_out_fifo.sv
// Four-entry synchronous FIFO; the head entry is read straight from storage flops.
module sched_out_fifo
  import merge_read_scheduler_pkg::*;
#(
  parameter int unsigned W = 39
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [2:0]   count
);

  logic [W-1:0] mem_q [OUT_FIFO_DEPTH];
  logic [W-1:0] mem_d [OUT_FIFO_DEPTH];
  logic [1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_push = push && (cnt_q != 3'(OUT_FIFO_DEPTH));
    do_pop  = pop && (cnt_q != 3'd0);
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 2'd1;
    end
    if (do_pop) begin
      rd_d = rd_q + 2'd1;
    end
    cnt_d = cnt_q + 3'(do_push) - 3'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(OUT_FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/merge_read_scheduler.sv
// Drains per-lane address-info FIFOs in lane order after the writer stalls,
// reads each address range from RAM and streams it out as one AXI-Stream segment.
module merge_read_scheduler
  import merge_read_scheduler_pkg::*;
#(
  parameter int unsigned RAM_AW      = 8,
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned TAM_WIDTH   = 2,
  parameter int unsigned FDSSI_WIDTH = 12,
  parameter int unsigned INFO_WIDTH  = FDSSI_WIDTH + 2 * RAM_AW
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               addr_finish,
  output logic                               merge_finish,
  input  logic [(1<<TAM_WIDTH)-1:0]          s_info_tvalid,
  output logic [(1<<TAM_WIDTH)-1:0]          s_info_tready,
  input  logic [(1<<TAM_WIDTH)*INFO_WIDTH-1:0] s_info,
  output logic                               ram_ren,
  output logic [RAM_AW-1:0]                  ram_raddr,
  input  logic [DATA_WIDTH-1:0]              ram_dout,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic                               m_tlast,
  output logic [DATA_WIDTH-1:0]              m_tdata,
  output logic [TAM_WIDTH+FDSSI_WIDTH-1:0]   m_tuser
);

  localparam int unsigned LANES     = 1 << TAM_WIDTH;
  localparam int unsigned USER_W    = TAM_WIDTH + FDSSI_WIDTH;
  localparam int unsigned PAYLOAD_W = DATA_WIDTH + 1 + USER_W;
  localparam int unsigned SADDR_LSB = saddr_lsb(RAM_AW);
  localparam int unsigned FDSSI_LSB = fdssi_lsb(RAM_AW);

  state_e                 state_q, state_d;
  logic                   armed_q, armed_d;
  logic [TAM_WIDTH-1:0]   lane_q, lane_d;
  logic [RAM_AW-1:0]      cur_q, cur_d, eaddr_q, eaddr_d;
  logic [FDSSI_WIDTH-1:0] fdssi_q, fdssi_d;
  logic                   rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [USER_W-1:0]      rd_user_q, rd_user_d;

  logic [INFO_WIDTH-1:0]  info_sel;
  logic                   lane_valid, credit_ok, issue_c, at_end;
  logic [2:0]             fifo_count;
  logic [PAYLOAD_W-1:0]   fifo_din, fifo_dout;

  always_comb begin
    info_sel = s_info[int'(lane_q) * INFO_WIDTH +: INFO_WIDTH];
  end

  // A word may be issued only if the buffer can still take it once it lands.
  assign lane_valid = s_info_tvalid[lane_q];
  assign credit_ok  = (fifo_count + 3'(rd_valid_q)) < 3'(OUT_FIFO_DEPTH);
  assign issue_c    = (state_q == ST_READ) && credit_ok;
  assign at_end     = (cur_q == eaddr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      lane_q     <= '0;
      cur_q      <= '0;
      eaddr_q    <= '0;
      fdssi_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_user_q  <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      lane_q     <= lane_d;
      cur_q      <= cur_d;
      eaddr_q    <= eaddr_d;
      fdssi_q    <= fdssi_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_user_q  <= rd_user_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | ~addr_finish;
    lane_d     = lane_q;
    cur_d      = cur_q;
    eaddr_d    = eaddr_q;
    fdssi_d    = fdssi_q;
    rd_valid_d = issue_c;
    rd_last_d  = issue_c && at_end;
    rd_user_d  = {lane_q, fdssi_q};
    case (state_q)
      ST_IDLE: begin
        if (armed_q && addr_finish) begin
          state_d = ST_SCAN;
          lane_d  = '0;
        end
      end
      ST_SCAN: begin
        if (lane_valid) begin
          cur_d   = info_sel[SADDR_LSB +: RAM_AW];
          eaddr_d = info_sel[EADDR_LSB +: RAM_AW];
          fdssi_d = info_sel[FDSSI_LSB +: FDSSI_WIDTH];
          state_d = ST_READ;
        end else if (lane_q == TAM_WIDTH'(LANES - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          lane_d = lane_q + TAM_WIDTH'(1);
        end
      end
      ST_READ: begin
        if (issue_c) begin
          cur_d = cur_q + RAM_AW'(1);
          if (at_end) state_d = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        if ((fifo_count == 3'd0) && !rd_valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        armed_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_ren       = issue_c;
    ram_raddr     = cur_q;
    merge_finish  = (state_q == ST_DONE);
    s_info_tready = '0;
    if ((state_q == ST_SCAN) && lane_valid) s_info_tready[lane_q] = 1'b1;
  end

  assign fifo_din = {ram_dout, rd_last_q, rd_user_q};
  assign m_tvalid = (fifo_count != 3'd0);
  assign {m_tdata, m_tlast, m_tuser} = fifo_dout;

  sched_out_fifo #(.W(PAYLOAD_W)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_valid_q),
    .din   (fifo_din),
    .pop   (m_tvalid && m_tready),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_merge_read_scheduler.sv
// Directed bench for merge_read_scheduler: lane FIFO and RAM models, stream logger,
// table-driven single-segment cases plus hand-written multi-cycle sequences.
module tb_merge_read_scheduler;

  localparam int LN = 4;
  localparam int IW = 28;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          addr_finish;
  logic          merge_finish;
  logic [LN-1:0] s_info_tvalid, s_info_tready;
  logic [LN*IW-1:0] s_info;
  logic          ram_ren;
  logic [7:0]    ram_raddr;
  logic [23:0]   ram_dout = '0;
  logic          m_tvalid, m_tready, m_tlast;
  logic [23:0]   m_tdata;
  logic [13:0]   m_tuser;

  merge_read_scheduler dut (
    .clk(clk), .rst_n(rst_n), .addr_finish(addr_finish), .merge_finish(merge_finish),
    .s_info_tvalid(s_info_tvalid), .s_info_tready(s_info_tready), .s_info(s_info),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tuser(m_tuser)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] exp_word(input logic [7:0] a);
    return {8'hA5, a ^ 8'h3C, a};
  endfunction

  // RAM model: one-cycle read latency
  always @(posedge clk) if (ram_ren) ram_dout <= exp_word(ram_raddr);

  // Lane FIFO models
  logic [IW-1:0] lmem [LN][64];
  int lhd [LN] = '{default: 0};
  int ltl [LN] = '{default: 0};

  always_comb begin
    for (int i = 0; i < LN; i++) begin
      s_info_tvalid[i]      = (ltl[i] != lhd[i]);
      s_info[i*IW +: IW]    = lmem[i][lhd[i] % 64];
    end
  end

  always @(posedge clk)
    for (int i = 0; i < LN; i++)
      if (s_info_tready[i] && s_info_tvalid[i]) lhd[i] <= lhd[i] + 1;

  // Back-pressure pattern 1,0,0,1
  logic       bp_en = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;
  logic [1:0] bp_phase = '0;
  always @(posedge clk) bp_phase <= bp_phase + 2'd1;
  assign m_tready = !bp_en || rdy_pat[bp_phase];

  // Logger
  logic [7:0]  raddr_log [256];
  int          rcyc_log  [256];
  logic [23:0] bdata [256];
  logic        blast [256];
  logic [13:0] buser [256];
  int          bcyc  [256];
  int nren = 0, nbeat = 0, nfin = 0, fin_cyc = 0, ovf = 0, occ = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
    end else begin
      if (ram_ren) begin
        if (occ >= 4) ovf++;
        if (nren < 256) begin raddr_log[nren] = ram_raddr; rcyc_log[nren] = cyc; end
        nren++;
      end
      if (m_tvalid && m_tready) begin
        if (nbeat < 256) begin
          bdata[nbeat] = m_tdata; blast[nbeat] = m_tlast;
          buser[nbeat] = m_tuser; bcyc[nbeat] = cyc;
        end
        nbeat++;
      end
      if ($countones(s_info_tready) > 1) ovf++;
      if (merge_finish) begin nfin++; fin_cyc = cyc; end
      occ = occ + (ram_ren ? 1 : 0) - ((m_tvalid && m_tready) ? 1 : 0);
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input int lane, input logic [11:0] f, input logic [7:0] s, input logic [7:0] e);
    lmem[lane][ltl[lane] % 64] = {f, s, e};
    ltl[lane] = ltl[lane] + 1;
  endtask

  // Raise addr_finish, wait for merge_finish; optionally drop the level afterwards.
  task automatic run_merge(input bit drop, output int c0);
    int  f0;
    bit  ok;
    f0 = nfin; c0 = cyc; ok = 1'b0;
    addr_finish = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (nfin != f0) begin ok = 1'b1; break; end
    end
    chk("merge_finish_seen", 64'(ok), 64'd1);
    if (drop) begin
      addr_finish = 1'b0;
      tick(2);
    end
  endtask

  typedef struct {
    int          lane;
    logic [11:0] fdssi;
    logic [7:0]  s, e;
    bit          bp;
    int          len;
  } seg_t;

  seg_t tv [5];

  initial begin
    int c0, b0, r0, f0, o0;
    logic [7:0] a;

    tv[0] = '{0, 12'h012, 8'h10, 8'h13, 1'b0, 4};
    tv[1] = '{2, 12'hABC, 8'hFE, 8'h01, 1'b0, 4};
    tv[2] = '{3, 12'h001, 8'h55, 8'h55, 1'b0, 1};
    tv[3] = '{1, 12'hFFF, 8'hF0, 8'hF5, 1'b1, 6};
    tv[4] = '{0, 12'h007, 8'hFF, 8'h00, 1'b0, 2};

    rst_n = 1'b0; addr_finish = 1'b0;
    tick(2);
    chk("reset_outputs", {merge_finish, s_info_tready, ram_ren, ram_raddr, m_tvalid,
                          m_tlast, m_tdata, m_tuser}, 64'd0);
    rst_n = 1'b1;
    tick(3);

    // Single-entry segments
    for (int t = 0; t < 5; t++) begin
      b0 = nbeat; r0 = nren; f0 = nfin; o0 = ovf;
      push_entry(tv[t].lane, tv[t].fdssi, tv[t].s, tv[t].e);
      bp_en = tv[t].bp;
      run_merge(1'b1, c0);
      bp_en = 1'b0;
      chk($sformatf("t%0d_beats", t), 64'(nbeat - b0), 64'(tv[t].len));
      chk($sformatf("t%0d_reads", t), 64'(nren - r0), 64'(tv[t].len));
      for (int k = 0; k < tv[t].len; k++) begin
        a = tv[t].s + 8'(k);
        chk($sformatf("t%0d_raddr%0d", t, k), 64'(raddr_log[r0+k]), 64'(a));
        chk($sformatf("t%0d_data%0d", t, k), 64'(bdata[b0+k]), 64'(exp_word(a)));
        chk($sformatf("t%0d_last%0d", t, k), 64'(blast[b0+k]), 64'(k == tv[t].len - 1));
        chk($sformatf("t%0d_user%0d", t, k), 64'(buser[b0+k]), 64'({2'(tv[t].lane), tv[t].fdssi}));
        if (!tv[t].bp)
          chk($sformatf("t%0d_rcyc%0d", t, k), 64'(rcyc_log[r0+k] - c0), 64'(2 + tv[t].lane + k));
      end
      if (!tv[t].bp) chk($sformatf("t%0d_first_beat_cyc", t), 64'(bcyc[b0] - c0), 64'(4 + tv[t].lane));
      chk($sformatf("t%0d_finish_once", t), 64'(nfin - f0), 64'd1);
      chk($sformatf("t%0d_no_overflow", t), 64'(ovf - o0), 64'd0);
    end

    // Three lanes: 1, 0, 2 one-word entries
    b0 = nbeat; r0 = nren; f0 = nfin;
    push_entry(0, 12'h101, 8'h20, 8'h20);
    push_entry(2, 12'h202, 8'h30, 8'h30);
    push_entry(2, 12'h203, 8'h40, 8'h40);
    run_merge(1'b1, c0);
    chk("ml_beats", 64'(nbeat - b0), 64'd3);
    chk("ml_user0", 64'(buser[b0]),   64'(14'h0101));
    chk("ml_user1", 64'(buser[b0+1]), 64'(14'h2202));
    chk("ml_user2", 64'(buser[b0+2]), 64'(14'h2203));
    chk("ml_data2", 64'(bdata[b0+2]), 64'(exp_word(8'h40)));
    chk("ml_lasts", 64'({blast[b0], blast[b0+1], blast[b0+2]}), 64'(3'b111));
    chk("ml_rcyc0", 64'(rcyc_log[r0]   - c0), 64'd2);
    chk("ml_rcyc1", 64'(rcyc_log[r0+1] - c0), 64'd6);
    chk("ml_rcyc2", 64'(rcyc_log[r0+2] - c0), 64'd8);
    chk("ml_finish_once", 64'(nfin - f0), 64'd1);

    // All lanes empty, then re-arm only after addr_finish goes low
    r0 = nren; f0 = nfin;
    run_merge(1'b0, c0);
    chk("empty_fin_cyc", 64'(fin_cyc - c0), 64'd6);
    chk("empty_no_reads", 64'(nren - r0), 64'd0);
    tick(20);
    chk("no_rearm_while_high", 64'(nfin - f0), 64'd1);
    addr_finish = 1'b0;
    tick(1);
    run_merge(1'b1, c0);
    chk("rearm_fin_cyc", 64'(fin_cyc - c0), 64'd6);
    chk("rearm_fin_count", 64'(nfin - f0), 64'd2);

    // Reset in the middle of READ
    push_entry(0, 12'h005, 8'h00, 8'h0F);
    addr_finish = 1'b1;
    tick(4);
    chk("mid_read_ren", 64'(ram_ren), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {merge_finish, s_info_tready, ram_ren, ram_raddr, m_tvalid,
                              m_tlast, m_tdata, m_tuser}, 64'd0);
    tick(2);
    rst_n = 1'b1;
    r0 = nren; f0 = nfin;
    tick(15);
    chk("post_reset_no_reads", 64'(nren - r0), 64'd0);
    chk("post_reset_no_finish", 64'(nfin - f0), 64'd0);
    addr_finish = 1'b0;
    tick(1);
    b0 = nbeat;
    push_entry(0, 12'h006, 8'h70, 8'h71);
    run_merge(1'b1, c0);
    chk("restart_beats", 64'(nbeat - b0), 64'd2);
    chk("restart_data1", 64'(bdata[b0+1]), 64'(exp_word(8'h71)));
    chk("restart_lasts", 64'({blast[b0], blast[b0+1]}), 64'(2'b01));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/merge_read_scheduler.md
# merge_read_scheduler

- Reads back a RAM buffer after the frame writer has filled it and stopped on a father-domain boundary.
- Drains the writer's per-lane address-info FIFOs in lane order. Each entry is {FDSSI, start address, end address}; the block issues RAM reads over that address range and streams the words out as one AXI-Stream segment per entry.
- When the writer's finished level is seen and every lane is drained, the block pulses `merge_finish` so the writer resumes.

## Interface
Parameters:
- `RAM_AW`, 8: RAM address width.
- `DATA_WIDTH`, 24: RAM word / stream data width.
- `TAM_WIDTH`, 2: lane select width; `LANES` = 2**TAM_WIDTH.
- `FDSSI_WIDTH`, 12: FDSSI field width.
- `INFO_WIDTH`, FDSSI_WIDTH+2*RAM_AW: info entry width, fixed by the other parameters.

Ports:
- Clocking and reset:
  - `clk`, in, 1: single clock, all logic rising edge.
  - `rst_n`, in, 1: asynchronous, active-low reset.
- Writer control:
  - `addr_finish`, in, 1: writer level, high = buffer full and writer stalled.
  - `merge_finish`, out, 1: one-cycle pulse, merge complete.
- Address-info FIFOs:
  - `s_info_tvalid`, in, LANES: per-lane FIFO valid.
  - `s_info_tready`, out, LANES: per-lane pop, one-hot or zero.
  - `s_info`, in, LANES*INFO_WIDTH: lane i occupies bits [i*INFO_WIDTH +: INFO_WIDTH]. Field order MSB to LSB is {fdssi, s_addr, e_addr}.
- RAM read port:
  - `ram_ren`, out, 1: read enable.
  - `ram_raddr`, out, RAM_AW: read address.
  - `ram_dout`, in, DATA_WIDTH: read data, valid exactly 1 cycle after `ram_ren`.
- Output stream:
  - `m_tvalid` out, `m_tready` in, `m_tlast` out: 1 bit each.
  - `m_tdata`, out, DATA_WIDTH.
  - `m_tuser`, out, TAM_WIDTH+FDSSI_WIDTH: {lane, fdssi} of the current segment.

## Operation
- State machine: IDLE, SCAN, READ, DRAIN, DONE.
- IDLE:
  - `armed` is set after `addr_finish` has been sampled low at least once since reset or since the last DONE.
  - Move to SCAN with `lane`=0 when `armed` and `addr_finish`=1.
- SCAN:
  - If `s_info_tvalid[lane]`=1: assert `s_info_tready[lane]` in the same cycle; latch s_addr into `cur`, e_addr, fdssi and lane; go to READ.
  - Otherwise, if `lane`=LANES-1 go to DRAIN, else increment `lane` and stay in SCAN.
- READ:
  - Assert `ram_ren` with `ram_raddr`=`cur` whenever occupancy + inflight < 4. The output buffer is a 4-entry FIFO; inflight is 0 or 1.
  - Each word is tagged last when `cur`==e_addr. After issuing that word, return to SCAN on the same lane.
  - `cur` increments modulo 2**RAM_AW, so a range with e_addr < s_addr wraps through address 0.
  - s_addr==e_addr is a one-word segment. Segment length is (e_addr − s_addr) mod 2**RAM_AW + 1.
- DRAIN: wait until the buffer is empty and inflight=0, then go to DONE.
- DONE: `merge_finish`=1 for exactly one cycle; clear `armed`; go to IDLE.
- Output buffer:
  - Captures {`ram_dout`, last, lane, fdssi} one cycle after `ram_ren`.
  - `m_*` are driven from the buffer head and follow AXI rules: data is held stable while `m_tvalid`=1 and `m_tready`=0.
- `s_info` is sampled only while the writer is stalled, so lane contents are static during a merge. An empty lane is skipped in one cycle.
- A low-going `addr_finish` during SCAN, READ or DRAIN is ignored; the merge completes.

## Timing
- Reset values: `merge_finish`, `s_info_tready`, `ram_ren`, `ram_raddr`, `m_tvalid`, `m_tlast`, `m_tdata`, `m_tuser` all 0; state IDLE; `armed`=0.
- Reset asserted mid-merge aborts immediately. The buffer is cleared and no `merge_finish` is issued.
- Latency from `addr_finish` sampled high (cycle 0):
  - SCAN at cycle 1.
  - First `ram_ren` at cycle 2 if lane 0 is non-empty.
  - First `m_tvalid` at cycle 4: data captured at cycle 3, registered head at cycle 4.
- Throughput: one word per cycle sustained while `m_tready`=1. The SCAN hop between entries costs 1 bubble per entry.
- All-lanes-empty merge: SCAN occupies cycles 1..LANES, then DRAIN for 1 cycle. `merge_finish` is asserted in cycle LANES+2.
- `ram_ren` never asserts while the buffer could overflow. Back-pressure on `m_tready` stalls issue within 1 cycle.

## Structure
- Shared package holds:
  - The info-field slicing offsets (FDSSI/SADDR/EADDR positions), used identically by the frame writer.
  - The state encoding.
- Sub-module `sched_out_fifo`: 4-entry synchronous FIFO with registered head. Ports are push, pop, count, and the {data, last, user} payload.

## Test plan
- Lane 0 holds {fdssi=0x12, s=0x10, e=0x13}, other lanes empty, `m_tready`=1. Expect:
  - Reads at 0x10..0x13 at cycles 2..5.
  - 4 beats, `m_tlast` on the 4th, `m_tuser`={0,0x12}.
  - `merge_finish` pulses once.
- Wrap: entry s=0xFE, e=0x01 → `ram_raddr` sequence FE, FF, 00, 01; tlast on the beat read from 0x01.
- Three lanes with 1, 0 and 2 entries of 1 word each: output is lane order 0, 2, 2 with tlast on every beat; lane 1 is skipped in one SCAN cycle.
- `m_tready` toggles 1-0-0-1 over a 6-word segment: no beat is lost or duplicated, at most 4 words are buffered, and `ram_ren` is held off while full.
- All lanes empty with LANES=4: `merge_finish` pulses at cycle 6 and no `ram_ren` occurs. With `addr_finish` held high afterwards, no second merge starts until it goes low and then high again.
- `rst_n` asserted mid-READ: all outputs are 0 in the same cycle; after release the block returns to IDLE and requires `armed` before restarting.
